seq_chunk_adder: RTL
====================

# seq_chunk_adder

Parametrised multi-cycle adder/subtractor for the multiply-accumulate datapath. It computes A ± ext(B) over ceil(A_WIDTH/CHUNK) cycles, using one CHUNK-bit ripple slice and a registered carry, and returns an (A_WIDTH+1)-bit result. A valid/ready handshake on each side lets it sit between the partial-product stage and the accumulator write-back. It generalises the fixed 61+48 zero-extended adder with configurable widths, sign or zero extension of B, subtract mode, carry-in and pipelined flow control.

## Interface
- A_WIDTH, 61: width of operand A; result width is A_WIDTH+1.
- B_WIDTH, 48: width of operand B; B_WIDTH <= A_WIDTH is required and checked at elaboration.
- CHUNK, 16: bits processed per cycle; 1 <= CHUNK <= A_WIDTH.
- SIGN_EXT_B, 0: 0 zero-extends B to A_WIDTH, 1 sign-extends it.
- N (localparam): ceil(A_WIDTH/CHUNK), the number of compute cycles.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  A_WIDTH  operand A.
- b  in  B_WIDTH  operand B.
- op_sub  in  1  0 gives A + ext(B) + cin; 1 gives A - ext(B).
- cin  in  1  carry-in, used in add mode only.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- sum  out  A_WIDTH+1  result; sum[A_WIDTH] is the carry-out.

## Operation
- States:
  - IDLE → RUN on in_valid & in_ready.
  - RUN → DONE when the chunk index reaches N-1.
  - DONE → IDLE on out_ready.
- Capture on the accepting edge:
  - a_reg ← a.
  - b_reg ← ext(b), inverted when op_sub=1.
  - carry ← op_sub ? 1 : cin.
  - idx ← 0.
  - sum_reg ← 0.
- Inputs are sampled only at acceptance. Changes on a, b, op_sub or cin during RUN or DONE have no effect.
- Each RUN cycle k (0..N-1): {c, s} = a_reg[slice k] + b_reg[slice k] + carry.
  - Slice k covers bits [k·CHUNK, min((k+1)·CHUNK, A_WIDTH)-1]; the last slice may be narrower.
  - sum_reg[slice k] ← s; carry ← c; idx ← idx+1.
- On the last slice, its carry-out is written to sum_reg[A_WIDTH].
- Arithmetic:
  - sum[A_WIDTH-1:0] = (A ± ext(B) [+cin]) mod 2^A_WIDTH.
  - In add mode, sum[A_WIDTH] = unsigned carry-out.
  - In subtract mode, sum[A_WIDTH] = 1 means no borrow (A >= ext(B), both read as unsigned A_WIDTH-bit values).
- sum is driven directly from sum_reg. It is stable throughout DONE and holds its value after returning to IDLE until the next acceptance clears it.
- Back-pressure: while out_ready is low in DONE, the block stays in DONE with sum and out_valid held; in_ready stays low.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state=IDLE, in_ready=1, out_valid=0, sum=0, idx=0, carry=0.
- Reset asserted mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- Latency: the acceptance edge is E0; slices complete on edges E1..EN; out_valid rises after EN.
  - For the default parameters (N=4), out_valid is high in the 4th cycle after acceptance.
- Throughput: one operation per N+2 cycles with out_ready tied high (accept, N compute cycles, one DONE cycle).
- in_ready is low from the accepting edge until the edge on which DONE & out_ready is seen; the next acceptance occurs no earlier than the following edge.
- N=1 (CHUNK >= A_WIDTH): RUN lasts exactly one cycle.

## Test plan
- Defaults, add, a=2^61-1, b=1, cin=0, out_ready=1 → out_valid rises 4 cycles after accept; sum=62'h2000_0000_0000_0000 (only bit 61 set).
- Subtract, a=5, b=7, op_sub=1 → sum[60:0]=2^61-2, sum[61]=0. Then a=7, b=5 → sum=62'h2000_0000_0000_0002.
- SIGN_EXT_B=1, add, a=10, b=48'hFFFF_FFFF_FFFF (-1) → sum[60:0]=9, sum[61]=1.
- Hold out_ready=0 for 10 cycles in DONE while toggling a and b → sum, out_valid=1 and in_ready=0 all stable; one cycle of out_ready=1 → IDLE on the next edge, in_ready=1.
- Pulse rst_n low asynchronously during RUN at idx=2 → out_valid=0, sum=0 and in_ready=1 immediately. A fresh a=1, b=1, cin=1 then yields sum=3 with no residue from the aborted operation.
- Randomised sweep: A_WIDTH=61/CHUNK=16, A_WIDTH=61/CHUNK=61 and A_WIDTH=17/CHUNK=4/B_WIDTH=17; 2000 operations with random op_sub, cin and out_ready → every result matches the reference model, and latency is always N.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle A +/- ext(B) built from one CHUNK-bit ripple
// slice and a registered carry. Operands are captured on acceptance, one slice
// is resolved per RUN cycle, and the (A_WIDTH+1)-bit result is presented in
// DONE under a valid/ready handshake.
module seq_chunk_adder #(
  parameter int A_WIDTH    = 61,
  parameter int B_WIDTH    = 48,
  parameter int CHUNK      = 16,
  parameter int SIGN_EXT_B = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               op_sub,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH:0]   sum
);

  localparam int N      = (A_WIDTH + CHUNK - 1) / CHUNK;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int LAST_W = A_WIDTH - (N - 1) * CHUNK;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  if (B_WIDTH > A_WIDTH) begin : g_chk_b_width
    $error("seq_chunk_adder: B_WIDTH must not exceed A_WIDTH");
  end
  if (CHUNK < 1 || CHUNK > A_WIDTH) begin : g_chk_chunk
    $error("seq_chunk_adder: CHUNK must lie in 1..A_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                 accept;
  logic [A_WIDTH-1:0]   a_reg;
  logic [A_WIDTH-1:0]   b_reg;
  logic [A_WIDTH-1:0]   b_ext;
  logic signed [B_WIDTH-1:0] b_s;
  logic                 carry;
  logic [IDX_W-1:0]     idx;
  logic [A_WIDTH:0]     sum_reg;
  logic [A_WIDTH:0]     sum_next;
  logic [CHUNK-1:0]     a_chunk;
  logic [CHUNK-1:0]     b_chunk;
  logic [CHUNK:0]       chunk_sum;

  assign b_s    = b;
  assign b_ext  = (SIGN_EXT_B != 0) ? A_WIDTH'(b_s) : A_WIDTH'(b);
  assign accept = in_valid & in_ready;
  assign sum    = sum_reg;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs decoded from the state
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (idx == IDX_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slice select and ripple add; bits past A_WIDTH in the last slice stay zero
  // so the final carry-out lands on bit LAST_W of the slice sum
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < A_WIDTH; i++) begin
      if (idx == IDX_W'(i / CHUNK)) begin
        a_chunk[i % CHUNK] = a_reg[i];
        b_chunk[i % CHUNK] = b_reg[i];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    sum_next  = sum_reg;
    for (int i = 0; i < A_WIDTH; i++) begin
      if (idx == IDX_W'(i / CHUNK)) begin
        sum_next[i] = chunk_sum[i % CHUNK];
      end
    end
    if (idx == IDX_LAST) begin
      sum_next[A_WIDTH] = chunk_sum[LAST_W];
    end
  end

  // Operand capture; subtraction folds into addition of the inverted operand
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= a;
      b_reg <= op_sub ? ~b_ext : b_ext;
    end
  end

  // Carry, slice index and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry   <= 1'b0;
      idx     <= '0;
      sum_reg <= '0;
    end else if (accept) begin
      carry   <= op_sub | cin;
      idx     <= '0;
      sum_reg <= '0;
    end else if (state_q == RUN) begin
      carry   <= chunk_sum[CHUNK];
      idx     <= idx + IDX_W'(1);
      sum_reg <= sum_next;
    end
  end

endmodule
